// File: rtl/matrix_inv_pkg.sv
// Shared definitions for the 2x2 matrix inverter.
//
// Holds the default widths, the constants derived from them, the output
// saturation limits at the default output width, and the controller state
// encoding. Modules that are parameterised re-derive the width-dependent
// constants from their own parameters. The package values serve as defaults.
package matrix_inv_pkg;

  localparam int DEF_IN_W   = 16;
  localparam int DEF_FRAC_W = 16;
  localparam int DEF_OUT_W  = 32;

  localparam int DEF_DET_W = 2 * DEF_IN_W + 1;
  localparam int DEF_Q_W   = DEF_IN_W + DEF_FRAC_W;

  localparam logic [DEF_OUT_W-1:0] DEF_SAT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam logic [DEF_OUT_W-1:0] DEF_SAT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_SUB,
    ST_CHK,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/matrix_inv_2x2_serial_divider.sv
// Unsigned restoring divider. It produces one quotient bit per clock.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : loads dividend/divisor. It may be asserted on the done
//                cycle to chain the next division without a gap.
//   dividend   : DVD_W-bit unsigned dividend
//   divisor    : DVS_W-bit unsigned divisor (must be non-zero)
//   done       : high on the last iteration cycle, DVD_W cycles after start
//   quotient   : full quotient. It is valid only while done is high.
module serial_divider
  import matrix_inv_pkg::*;
#(
  parameter int DVD_W = DEF_Q_W,
  parameter int DVS_W = DEF_DET_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [DVD_W-1:0] dvd_sh;
  logic [DVD_W-1:0] quot;
  logic [CNT_W-1:0] cnt;
  logic             running;

  logic [DVS_W:0]   trial;
  logic [DVS_W-1:0] diff;
  logic             fits;
  logic [DVS_W-1:0] rem_next;

  // One restoring step. Shift in the next dividend bit, then subtract if the
  // partial remainder allows it. The remainder is always below the divisor, so
  // the difference fits in DVS_W bits whenever the subtraction is taken.
  // The quotient exposed on done already includes the final bit. This lets
  // the consumer capture it on the same edge that finishes the division.
  always_comb begin
    trial    = {rem, dvd_sh[DVD_W-1]};
    fits     = (trial >= {1'b0, dvs});
    diff     = trial[DVS_W-1:0] - dvs;
    rem_next = fits ? diff : trial[DVS_W-1:0];
    done     = running && (cnt == CNT_W'(1));
    quotient = {quot[DVD_W-2:0], fits};
  end

  // Iteration registers. A start always wins, which allows back-to-back reuse
  // on the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      dvs     <= '0;
      dvd_sh  <= '0;
      quot    <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= '0;
      dvs     <= divisor;
      dvd_sh  <= dividend;
      quot    <= '0;
      cnt     <= CNT_W'(DVD_W);
      running <= 1'b1;
    end else if (running) begin
      rem     <= rem_next;
      dvd_sh  <= {dvd_sh[DVD_W-2:0], 1'b0};
      quot    <= {quot[DVD_W-2:0], fits};
      cnt     <= cnt - CNT_W'(1);
      running <= (cnt != CNT_W'(1));
    end
  end

endmodule

// File: rtl/matrix_inv_2x2.sv
// Computes the signed fixed-point inverse of a 2x2 matrix with unsigned entries.
//
// Ports:
//   I_sys_clk, I_sys_rstn : clock (rising edge), asynchronous active-low reset
//   I_start               : one-cycle job request. It is accepted only in IDLE.
//   I_a11..I_a22          : unsigned matrix entries. They are latched on acceptance.
//   O_busy                : job in progress (MUL through DIV)
//   O_valid               : one-cycle pulse when the result outputs update
//   O_singular            : the last job had a zero determinant
//   O_sat                 : at least one element of the last job was clamped
//   O_det                 : signed determinant of the last job
//   O_inv11..O_inv22      : signed Q(OUT_W-FRAC_W).FRAC_W inverse elements
//
// The four elements share one serial divider. They are processed in the
// order 11, 12, 21, 22, with no idle cycles between them.
module matrix_inv_2x2
  import matrix_inv_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                    I_sys_clk,
  input  logic                    I_sys_rstn,
  input  logic                    I_start,
  input  logic [IN_W-1:0]         I_a11,
  input  logic [IN_W-1:0]         I_a12,
  input  logic [IN_W-1:0]         I_a21,
  input  logic [IN_W-1:0]         I_a22,
  output logic                    O_busy,
  output logic                    O_valid,
  output logic                    O_singular,
  output logic                    O_sat,
  output logic signed [2*IN_W:0]  O_det,
  output logic signed [OUT_W-1:0] O_inv11,
  output logic signed [OUT_W-1:0] O_inv12,
  output logic signed [OUT_W-1:0] O_inv21,
  output logic signed [OUT_W-1:0] O_inv22
);

  localparam int DET_W = 2 * IN_W + 1;
  localparam int Q_W   = IN_W + FRAC_W;
  localparam int EXT_W = ((Q_W > OUT_W) ? Q_W : OUT_W) + 1;

  localparam logic [EXT_W-1:0] NEG_LIMIT = EXT_W'(1) << (OUT_W - 1);
  localparam logic [EXT_W-1:0] POS_LIMIT = NEG_LIMIT - EXT_W'(1);
  localparam logic [OUT_W-1:0] SAT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

  state_t state, next_state;

  logic [IN_W-1:0]         a11_r, a12_r, a21_r, a22_r;
  logic [2*IN_W-1:0]       prod_a, prod_b;
  logic signed [DET_W-1:0] det_r;
  logic [1:0]              idx;
  logic [OUT_W-1:0]        stage11, stage12, stage21;
  logic                    sat_acc;

  logic             det_zero;
  logic             det_neg;
  logic [DET_W-1:0] det_mag;
  logic             div_start;
  logic [1:0]       sel;
  logic [IN_W-1:0]  sel_mag;
  logic [Q_W-1:0]   dividend;
  logic             div_done;
  logic [Q_W-1:0]   div_quot;
  logic             cur_neg;
  logic [EXT_W-1:0] q_ext;
  logic [OUT_W-1:0] cur_res;
  logic             cur_sat;

  // Controller state register.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the status outputs that follow the state.
  // A start request outside IDLE is ignored. DONE always returns to IDLE,
  // so a request in the cycle after the pulse is accepted.
  always_comb begin
    next_state = state;
    O_busy     = 1'b0;
    O_valid    = 1'b0;
    case (state)
      ST_IDLE: if (I_start) next_state = ST_MUL;
      ST_MUL: begin
        O_busy     = 1'b1;
        next_state = ST_SUB;
      end
      ST_SUB: begin
        O_busy     = 1'b1;
        next_state = ST_CHK;
      end
      ST_CHK: begin
        O_busy     = 1'b1;
        next_state = det_zero ? ST_DONE : ST_DIV;
      end
      ST_DIV: begin
        O_busy = 1'b1;
        if (div_done && (idx == 2'd3)) next_state = ST_DONE;
      end
      ST_DONE: begin
        O_valid    = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Divider feed. In CHK the first element (11) is launched. Each later
  // element is launched on the done cycle of the previous one. Numerator
  // magnitudes are a22, a12, a21, a11. The signs are tracked separately.
  always_comb begin
    det_zero  = (det_r == '0);
    det_neg   = det_r[DET_W-1];
    det_mag   = det_neg ? -det_r : det_r;
    div_start = ((state == ST_CHK) && !det_zero) ||
                ((state == ST_DIV) && div_done && (idx != 2'd3));
    sel       = (state == ST_CHK) ? 2'd0 : idx + 2'd1;
    case (sel)
      2'd0:    sel_mag = a22_r;
      2'd1:    sel_mag = a12_r;
      2'd2:    sel_mag = a21_r;
      default: sel_mag = a11_r;
    endcase
    dividend = {sel_mag, {FRAC_W{1'b0}}};
  end

  serial_divider #(
    .DVD_W(Q_W),
    .DVS_W(DET_W)
  ) u_div (
    .clk     (I_sys_clk),
    .rst_n   (I_sys_rstn),
    .start   (div_start),
    .dividend(dividend),
    .divisor (det_mag),
    .done    (div_done),
    .quotient(div_quot)
  );

  // Sign and clamp the element that the divider is finishing now.
  // The off-diagonal numerators are negated. A zero magnitude gives a zero
  // quotient, and negating zero is still zero.
  // A negative result can reach one step further than a positive one
  // (-2^(OUT_W-1)), so each sign has its own limit.
  always_comb begin
    cur_neg = ((idx == 2'd1) || (idx == 2'd2)) ^ det_neg;
    q_ext   = EXT_W'(div_quot);
    cur_sat = 1'b0;
    if (!cur_neg) begin
      if (q_ext > POS_LIMIT) begin
        cur_res = SAT_MAX;
        cur_sat = 1'b1;
      end else begin
        cur_res = q_ext[OUT_W-1:0];
      end
    end else begin
      if (q_ext > NEG_LIMIT) begin
        cur_res = SAT_MIN;
        cur_sat = 1'b1;
      end else begin
        cur_res = -q_ext[OUT_W-1:0];
      end
    end
  end

  // Datapath and result registers. The first three elements go into staging
  // registers. On the last divider completion, or on the singular exit from
  // CHK, every result output updates together on the edge that enters DONE.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      a11_r      <= '0;
      a12_r      <= '0;
      a21_r      <= '0;
      a22_r      <= '0;
      prod_a     <= '0;
      prod_b     <= '0;
      det_r      <= '0;
      idx        <= '0;
      stage11    <= '0;
      stage12    <= '0;
      stage21    <= '0;
      sat_acc    <= 1'b0;
      O_singular <= 1'b0;
      O_sat      <= 1'b0;
      O_det      <= '0;
      O_inv11    <= '0;
      O_inv12    <= '0;
      O_inv21    <= '0;
      O_inv22    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_start) begin
            a11_r <= I_a11;
            a12_r <= I_a12;
            a21_r <= I_a21;
            a22_r <= I_a22;
          end
        end
        ST_MUL: begin
          prod_a <= {{IN_W{1'b0}}, a11_r} * {{IN_W{1'b0}}, a22_r};
          prod_b <= {{IN_W{1'b0}}, a12_r} * {{IN_W{1'b0}}, a21_r};
        end
        ST_SUB: begin
          det_r <= $signed({1'b0, prod_a}) - $signed({1'b0, prod_b});
        end
        ST_CHK: begin
          idx     <= 2'd0;
          sat_acc <= 1'b0;
          if (det_zero) begin
            O_singular <= 1'b1;
            O_sat      <= 1'b0;
            O_det      <= det_r;
            O_inv11    <= '0;
            O_inv12    <= '0;
            O_inv21    <= '0;
            O_inv22    <= '0;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            idx     <= idx + 2'd1;
            sat_acc <= sat_acc | cur_sat;
            case (idx)
              2'd0: stage11 <= cur_res;
              2'd1: stage12 <= cur_res;
              2'd2: stage21 <= cur_res;
              default: begin
                O_singular <= 1'b0;
                O_sat      <= sat_acc | cur_sat;
                O_det      <= det_r;
                O_inv11    <= stage11;
                O_inv12    <= stage12;
                O_inv21    <= stage21;
                O_inv22    <= cur_res;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_inv_2x2.sv
// Directed, self-checking bench for matrix_inv_2x2 at the default widths.
// Each scenario task drives one job and compares results against
// hand-computed values. Latency is counted in cycles after the acceptance
// edge: the MUL cycle is cycle 1.
module tb_matrix_inv_2x2;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [15:0]        a11, a12, a21, a22;
  logic               busy, valid, singular, sat;
  logic signed [32:0] det;
  logic signed [31:0] inv11, inv12, inv21, inv22;

  int checks   = 0;
  int failures = 0;

  matrix_inv_2x2 dut (
    .I_sys_clk (clk),
    .I_sys_rstn(rst_n),
    .I_start   (start),
    .I_a11     (a11),
    .I_a12     (a12),
    .I_a21     (a21),
    .I_a22     (a22),
    .O_busy    (busy),
    .O_valid   (valid),
    .O_singular(singular),
    .O_sat     (sat),
    .O_det     (det),
    .O_inv11   (inv11),
    .O_inv12   (inv12),
    .O_inv21   (inv21),
    .O_inv22   (inv22)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a job in an IDLE cycle, holds start for exactly one edge, then
  // scrambles the inputs. The latched copy must be the one that is used.
  task automatic start_job(input logic [15:0] x11, input logic [15:0] x12,
                           input logic [15:0] x21, input logic [15:0] x22);
    @(negedge clk);
    a11 = x11; a12 = x12; a21 = x21; a22 = x22;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a11 = 16'hDEAD; a12 = 16'hBEEF; a21 = 16'h1234; a22 = 16'h5A5A;
  endtask

  // Returns the cycle index (1 = first negedge after the call) at which
  // O_valid is seen, or -1 if it never appears within the budget.
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0; start = 1'b0;
    a11 = '0; a12 = '0; a21 = '0; a22 = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, valid, singular, sat} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags got %b expected 0000", {busy, valid, singular, sat}); end
    checks++; if (det !== 33'sd0) begin failures++; $display("[TB] FAIL reset_det got %0d expected 0", det); end
    checks++; if ({inv11, inv12, inv21, inv22} !== 128'd0) begin failures++; $display("[TB] FAIL reset_inv got %h expected 0", {inv11, inv12, inv21, inv22}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_identity();
    int cyc;
    start_job(16'd256, 16'd0, 16'd0, 16'd256);
    wait_valid(cyc);
    checks++; if (cyc !== 132) begin failures++; $display("[TB] FAIL id_latency got %0d expected 132", cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL id_busy_at_valid got %b expected 0", busy); end
    checks++; if (det !== 33'sd65536) begin failures++; $display("[TB] FAIL id_det got %0d expected 65536", det); end
    checks++; if (inv11 !== 32'sd256 || inv22 !== 32'sd256) begin failures++; $display("[TB] FAIL id_diag got %0d,%0d expected 256,256", inv11, inv22); end
    checks++; if (inv12 !== 32'sd0 || inv21 !== 32'sd0) begin failures++; $display("[TB] FAIL id_offdiag got %0d,%0d expected 0,0", inv12, inv21); end
    checks++; if ({singular, sat} !== 2'b00) begin failures++; $display("[TB] FAIL id_flags got %b expected 00", {singular, sat}); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL id_valid_pulse got %b expected 0", valid); end
    checks++; if (inv11 !== 32'sd256) begin failures++; $display("[TB] FAIL id_hold got %0d expected 256", inv11); end
  endtask

  task automatic test_pos_det(input string tag);
    int cyc;
    start_job(16'd4, 16'd2, 16'd2, 16'd3);
    wait_valid(cyc);
    checks++; if (cyc !== 132) begin failures++; $display("[TB] FAIL %s_latency got %0d expected 132", tag, cyc); end
    checks++; if (det !== 33'sd8) begin failures++; $display("[TB] FAIL %s_det got %0d expected 8", tag, det); end
    checks++; if (inv11 !== 32'sd24576) begin failures++; $display("[TB] FAIL %s_inv11 got %0d expected 24576", tag, inv11); end
    checks++; if (inv12 !== -32'sd16384) begin failures++; $display("[TB] FAIL %s_inv12 got %0d expected -16384", tag, inv12); end
    checks++; if (inv21 !== -32'sd16384) begin failures++; $display("[TB] FAIL %s_inv21 got %0d expected -16384", tag, inv21); end
    checks++; if (inv22 !== 32'sd32768) begin failures++; $display("[TB] FAIL %s_inv22 got %0d expected 32768", tag, inv22); end
    checks++; if ({singular, sat} !== 2'b00) begin failures++; $display("[TB] FAIL %s_flags got %b expected 00", tag, {singular, sat}); end
  endtask

  // Negative determinant job, then a new job requested in the IDLE cycle
  // right after DONE. The second job also exercises truncation toward zero
  // for both signs.
  task automatic test_back_to_back();
    int cyc;
    start_job(16'd1, 16'd2, 16'd3, 16'd4);
    wait_valid(cyc);
    checks++; if (cyc !== 132) begin failures++; $display("[TB] FAIL neg_latency got %0d expected 132", cyc); end
    checks++; if (det !== -33'sd2) begin failures++; $display("[TB] FAIL neg_det got %0d expected -2", det); end
    checks++; if (inv11 !== -32'sd131072) begin failures++; $display("[TB] FAIL neg_inv11 got %0d expected -131072", inv11); end
    checks++; if (inv12 !== 32'sd65536) begin failures++; $display("[TB] FAIL neg_inv12 got %0d expected 65536", inv12); end
    checks++; if (inv21 !== 32'sd98304) begin failures++; $display("[TB] FAIL neg_inv21 got %0d expected 98304", inv21); end
    checks++; if (inv22 !== -32'sd32768) begin failures++; $display("[TB] FAIL neg_inv22 got %0d expected -32768", inv22); end
    start_job(16'd1, 16'd2, 16'd3, 16'd3);
    wait_valid(cyc);
    checks++; if (cyc !== 132) begin failures++; $display("[TB] FAIL b2b_latency got %0d expected 132", cyc); end
    checks++; if (det !== -33'sd3) begin failures++; $display("[TB] FAIL trunc_det got %0d expected -3", det); end
    checks++; if (inv11 !== -32'sd65536) begin failures++; $display("[TB] FAIL trunc_inv11 got %0d expected -65536", inv11); end
    checks++; if (inv12 !== 32'sd43690) begin failures++; $display("[TB] FAIL trunc_inv12 got %0d expected 43690", inv12); end
    checks++; if (inv21 !== 32'sd65536) begin failures++; $display("[TB] FAIL trunc_inv21 got %0d expected 65536", inv21); end
    checks++; if (inv22 !== -32'sd21845) begin failures++; $display("[TB] FAIL trunc_inv22 got %0d expected -21845", inv22); end
  endtask

  task automatic test_saturation();
    int cyc;
    start_job(16'd32768, 16'd1, 16'd65535, 16'd2);
    wait_valid(cyc);
    checks++; if (cyc !== 132) begin failures++; $display("[TB] FAIL sat_latency got %0d expected 132", cyc); end
    checks++; if (det !== 33'sd1) begin failures++; $display("[TB] FAIL sat_det got %0d expected 1", det); end
    checks++; if (inv11 !== 32'sd131072) begin failures++; $display("[TB] FAIL sat_inv11 got %0d expected 131072", inv11); end
    checks++; if (inv12 !== -32'sd65536) begin failures++; $display("[TB] FAIL sat_inv12 got %0d expected -65536", inv12); end
    checks++; if (inv21 !== 32'sh8000_0000) begin failures++; $display("[TB] FAIL sat_inv21 got %h expected 80000000", inv21); end
    checks++; if (inv22 !== 32'sh7FFF_FFFF) begin failures++; $display("[TB] FAIL sat_inv22 got %h expected 7fffffff", inv22); end
    checks++; if ({singular, sat} !== 2'b01) begin failures++; $display("[TB] FAIL sat_flags got %b expected 01", {singular, sat}); end
  endtask

  task automatic test_singular();
    int cyc;
    start_job(16'd2, 16'd4, 16'd1, 16'd2);
    wait_valid(cyc);
    checks++; if (cyc !== 4) begin failures++; $display("[TB] FAIL sing_latency got %0d expected 4", cyc); end
    checks++; if ({singular, sat} !== 2'b10) begin failures++; $display("[TB] FAIL sing_flags got %b expected 10", {singular, sat}); end
    checks++; if (det !== 33'sd0) begin failures++; $display("[TB] FAIL sing_det got %0d expected 0", det); end
    checks++; if ({inv11, inv12, inv21, inv22} !== 128'd0) begin failures++; $display("[TB] FAIL sing_inv got %h expected 0", {inv11, inv12, inv21, inv22}); end
  endtask

  // A start pulse in the middle of a job must be dropped. This yields exactly
  // one O_valid, with the results of the original job.
  task automatic test_ignored_start();
    int cyc;
    int extra;
    start_job(16'd256, 16'd0, 16'd0, 16'd256);
    repeat (49) @(negedge clk);
    a11 = 16'd2; a12 = 16'd4; a21 = 16'd1; a22 = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(cyc);
    checks++; if (cyc !== 83) begin failures++; $display("[TB] FAIL ign_latency got %0d expected 83", cyc); end
    checks++; if (inv11 !== 32'sd256 || singular !== 1'b0) begin failures++; $display("[TB] FAIL ign_result got inv11=%0d sing=%b expected 256,0", inv11, singular); end
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL ign_extra_valid got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid_job();
    int seen;
    start_job(16'd4, 16'd2, 16'd2, 16'd3);
    repeat (70) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, valid, singular, sat} !== 4'b0000) begin failures++; $display("[TB] FAIL mid_rst_flags got %b expected 0000", {busy, valid, singular, sat}); end
    checks++; if (det !== 33'sd0 || inv11 !== 32'sd0 || inv22 !== 32'sd0) begin failures++; $display("[TB] FAIL mid_rst_data got det=%0d inv11=%0d inv22=%0d expected 0", det, inv11, inv22); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL mid_no_valid got %0d expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_pos_det("pos");
    test_back_to_back();
    test_saturation();
    test_singular();
    test_ignored_start();
    test_reset_mid_job();
    test_pos_det("post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_inv_2x2.md
Name: matrix_inv_2x2

Overview:
- Downstream consumer of serial_matrix_mult.
- Takes the four accumulated 2x2 product-matrix entries a11/a12/a21/a22 and computes the determinant and adjugate.
- Produces the signed fixed-point inverse, one element at a time, through a shared serial restoring divider.
- Flags singular inputs and saturated outputs. Results feed the back-end that applies the inverse.

Parameters:
- IN_W, 16, width of each unsigned input matrix entry
- FRAC_W, 16, fractional bits of the output (Q(OUT_W-FRAC_W).FRAC_W)
- OUT_W, 32, width of each signed two's-complement output element

Ports:
- I_sys_clk  input  1  system clock, rising edge
- I_sys_rstn  input  1  asynchronous active-low reset
- I_start  input  1  one-cycle request; sampled only in IDLE
- I_a11  input  IN_W  unsigned entry a11
- I_a12  input  IN_W  unsigned entry a12
- I_a21  input  IN_W  unsigned entry a21
- I_a22  input  IN_W  unsigned entry a22
- O_busy  output  1  high from the cycle after start acceptance until O_valid
- O_valid  output  1  one-cycle pulse: results updated
- O_singular  output  1  det==0 for the last job
- O_sat  output  1  at least one element saturated in the last job
- O_det  output  2*IN_W+1  signed determinant of the last job
- O_inv11  output  OUT_W  signed inverse element 11
- O_inv12  output  OUT_W  signed inverse element 12
- O_inv21  output  OUT_W  signed inverse element 21
- O_inv22  output  OUT_W  signed inverse element 22

Behaviour:
- Reset (async, I_sys_rstn=0): state=IDLE, all outputs 0, divider cleared. Reset mid-job aborts the job with no O_valid pulse.
- Determinant:
  - det = a11*a22 - a12*a21, inputs zero-extended, 2*IN_W+1 bits signed, exact (no overflow possible).
  - Numerators: n11=+a22, n12=-a12, n21=-a21, n22=+a11.
- Per element:
  - q = floor(|n| * 2^FRAC_W / |det|), truncation toward zero.
  - Result sign = sign(n) XOR sign(det); a zero numerator gives 0.
  - If the signed result exceeds OUT_W range, clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1) and set O_sat.
- FSM:
  - IDLE: on I_start=1, latch inputs into registers (cycle 0). Go to MUL.
  - MUL (cycle 1): register the two products.
  - SUB (cycle 2): register det.
  - CHK (cycle 3):
    - det==0: go to DONE with singular=1 and all inv=0.
    - Otherwise go to DIV with element index 0.
  - DIV: divider runs IN_W+FRAC_W cycles per element (one quotient bit per cycle). Elements are processed in order 11, 12, 21, 22, back-to-back. The result register is written on the divider's done cycle. After element 22, go to DONE.
  - DONE:
    - O_valid=1 for one cycle, O_busy=0.
    - O_det, O_inv*, O_singular and O_sat update together on this cycle.
    - Return to IDLE.
- Latency at defaults, start at cycle 0:
  - Non-singular: O_valid at cycle 4+4*(IN_W+FRAC_W) = 132.
  - Singular: O_valid at cycle 4.
- Handshake:
  - I_start is ignored while O_busy=1 or in DONE.
  - A new I_start in IDLE on the cycle after DONE is accepted.
  - Outputs hold their last values until the next DONE.
  - Input ports may change freely after the acceptance cycle.

Decomposition:
- Shared package matrix_inv_pkg:
  - FSM state encoding (IDLE, MUL, SUB, CHK, DIV, DONE).
  - Default widths IN_W/FRAC_W/OUT_W.
  - Derived constants: DET_W=2*IN_W+1, Q_W=IN_W+FRAC_W.
  - Saturation limits.
- One sub-module, serial_divider:
  - Unsigned restoring divider, dividend Q_W bits, divisor DET_W bits.
  - Handshake: start/done; quotient Q_W bits.
  - Fixed latency of Q_W cycles from start to done.

Test Plan:
- Identity: a11=a22=256, a12=a21=0 -> det=65536; inv11=inv22=256, inv12=inv21=0; O_valid at cycle 132; singular=0, sat=0.
- Positive det: a11=4, a12=2, a21=2, a22=3 -> det=8; inv11=24576, inv12=-16384, inv21=-16384, inv22=32768.
- Negative det: a11=1, a12=2, a21=3, a22=4 -> det=-2; inv11=-131072, inv12=65536, inv21=98304, inv22=-32768.
- Singular: a11=2, a12=4, a21=1, a22=2 -> O_valid at cycle 4; singular=1; det=0; all inv=0.
- Saturation: a11=32768, a12=1, a21=65535, a22=2 -> det=1; inv11=131072, inv12=-65536, inv21=0x80000000, inv22=0x7FFFFFFF; sat=1.
- Control:
  - I_start pulsed at cycle 50 of a job -> ignored, exactly one O_valid.
  - Reset asserted at cycle 70 -> all outputs 0 immediately, no O_valid.
  - Next start after reset completes normally.
